pwm_capture: RTL and testbench



---
 rtl/pwm_pkg.sv | 13 +
 rtl/sync_2ff.sv | 25 ++
 rtl/pwm_capture.sv | 123 ++++++++++++
 tb/tb_pwm_capture.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared PWM types and defaults.
// Used by pwm_capture and the PWM generator.
package pwm_pkg;

  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW
  } pwm_state_t;

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for an async input.
// Ports: ck, rst (sync, active-high), d (async in), q (synced out).
module sync_2ff (
  input  logic ck,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic s1;
  logic s2;

  always_ff @(posedge ck) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= d;
      s2 <= s1;
    end
  end

  assign q = s2;

endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: measures PWM period/high time in ck cycles.
// Ports: ck, rst, pwm_in -> period, high, valid, stuck, stuck_lvl.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             ck,
  input  logic             rst,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high,
  output logic             valid,
  output logic             stuck,
  output logic             stuck_lvl
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic s2;
  logic s3;
  logic rise;
  logic fall;

  pwm_state_t       state, state_n;
  logic [CNT_W-1:0] per_cnt, per_n;
  logic [CNT_W-1:0] hi_cnt, hi_n;
  logic [CNT_W-1:0] period_n, high_n;
  logic             valid_n, stuck_n, lvl_n;
  logic [CNT_W-1:0] per_inc;
  logic             at_max;

  sync_2ff u_sync (
    .ck  (ck),
    .rst (rst),
    .d   (pwm_in),
    .q   (s2)
  );

  assign rise   = s2 & ~s3;
  assign fall   = ~s2 & s3;
  assign at_max = (per_cnt == CNT_MAX);
  // saturate so a fall at the limit can't wrap
  assign per_inc = at_max ? CNT_MAX : per_cnt + CNT_ONE;

  always_ff @(posedge ck) begin
    if (rst) begin
      s3        <= 1'b0;
      state     <= IDLE;
      per_cnt   <= '0;
      hi_cnt    <= '0;
      period    <= '0;
      high      <= '0;
      valid     <= 1'b0;
      stuck     <= 1'b0;
      stuck_lvl <= 1'b0;
    end else begin
      s3        <= s2;
      state     <= state_n;
      per_cnt   <= per_n;
      hi_cnt    <= hi_n;
      period    <= period_n;
      high      <= high_n;
      valid     <= valid_n;
      stuck     <= stuck_n;
      stuck_lvl <= lvl_n;
    end
  end

  always_comb begin
    state_n  = state;
    per_n    = per_cnt;
    hi_n     = hi_cnt;
    period_n = period;
    high_n   = high;
    valid_n  = 1'b0;
    stuck_n  = stuck;
    lvl_n    = stuck_lvl;
    unique case (state)
      IDLE: begin
        if (rise) begin
          per_n   = CNT_ONE;
          hi_n    = CNT_ONE;
          stuck_n = 1'b0;
          state_n = HIGH;
        end
      end
      HIGH: begin
        if (fall) begin
          per_n   = per_inc;
          state_n = LOW;
        end else if (at_max) begin
          stuck_n = 1'b1;
          lvl_n   = s2;
          state_n = IDLE;
        end else begin
          per_n = per_inc;
          hi_n  = hi_cnt + CNT_ONE;
        end
      end
      LOW: begin
        // rise takes priority over timeout
        if (rise) begin
          period_n = per_cnt;
          high_n   = hi_cnt;
          valid_n  = 1'b1;
          per_n    = CNT_ONE;
          hi_n     = CNT_ONE;
          state_n  = HIGH;
        end else if (at_max) begin
          stuck_n = 1'b1;
          lvl_n   = s2;
          state_n = IDLE;
        end else begin
          per_n = per_inc;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: scoreboard bench for pwm_capture.
// Narrow counters (CNT_W=4) so timeouts are reachable.
module tb_pwm_capture;

  localparam int W    = 4;
  localparam int MAXP = (1 << W) - 1;

  logic         ck = 1'b0;
  logic         rst = 1'b1;
  logic         pwm_in = 1'b0;
  logic [W-1:0] period;
  logic [W-1:0] high;
  logic         valid;
  logic         stuck;
  logic         stuck_lvl;

  int total = 0;
  int bad = 0;
  int qp[$];
  int qh[$];
  bit armed = 1'b0;
  int prev_h = 0;
  int prev_t = 0;
  bit last_v = 1'b0;

  pwm_capture #(.CNT_W(W)) dut (
    .ck        (ck),
    .rst       (rst),
    .pwm_in    (pwm_in),
    .period    (period),
    .high      (high),
    .valid     (valid),
    .stuck     (stuck),
    .stuck_lvl (stuck_lvl)
  );

  always #5 ck = ~ck;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  always @(negedge ck) begin
    if (valid) begin
      chk("valid_width", int'(last_v), 0);
      if (qp.size() == 0) begin
        chk("spurious_valid", int'(valid), 0);
      end else begin
        chk("period", int'(period), qp.pop_front());
        chk("high", int'(high), qh.pop_front());
      end
    end
    last_v = valid;
  end

  // a rise completes the previous period if it was armed and short enough
  task automatic push_prev();
    if (armed && prev_t <= MAXP) begin
      qp.push_back(prev_t);
      qh.push_back(prev_h);
    end
  endtask

  task automatic run_period(input int h, input int l);
    push_prev();
    armed  = 1'b1;
    prev_h = h;
    prev_t = h + l;
    pwm_in = 1'b1;
    repeat (h) @(posedge ck);
    #1 pwm_in = 1'b0;
    repeat (l) @(posedge ck);
    #1;
  endtask

  task automatic idle_cyc(input int n);
    repeat (n) @(posedge ck);
    #1;
  endtask

  initial begin
    rst    = 1'b1;
    pwm_in = 1'b0;
    repeat (3) @(posedge ck);
    @(negedge ck);
    chk("rst_period", int'(period), 0);
    chk("rst_high", int'(high), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_stuck", int'(stuck), 0);
    chk("rst_lvl", int'(stuck_lvl), 0);
    @(posedge ck);
    #1 rst = 1'b0;

    repeat (4) run_period(3, 5);
    repeat (6) run_period(1, 1);

    push_prev();
    armed  = 1'b0;
    pwm_in = 1'b1;
    repeat (17) @(posedge ck);
    @(negedge ck);
    chk("stuck_early", int'(stuck), 0);
    @(posedge ck);
    @(negedge ck);
    chk("stuck_hi", int'(stuck), 1);
    chk("stuck_lvl_hi", int'(stuck_lvl), 1);
    @(posedge ck);
    #1 pwm_in = 1'b0;
    idle_cyc(3);

    run_period(2, 3);
    chk("stuck_clr", int'(stuck), 0);
    chk("lvl_hold", int'(stuck_lvl), 1);
    run_period(2, 3);

    run_period(7, 8);
    run_period(7, 9);
    idle_cyc(4);
    chk("stuck_p16", int'(stuck), 1);
    chk("stuck_lvl_lo", int'(stuck_lvl), 0);
    run_period(3, 5);
    chk("stuck_clr2", int'(stuck), 0);

    run_period(3, 5);
    run_period(3, 4);
    rst = 1'b1;
    @(posedge ck);
    #1 rst = 1'b0;
    armed = 1'b0;
    @(negedge ck);
    chk("mid_period", int'(period), 0);
    chk("mid_high", int'(high), 0);
    chk("mid_valid", int'(valid), 0);
    chk("mid_stuck", int'(stuck), 0);
    chk("mid_lvl", int'(stuck_lvl), 0);
    @(posedge ck);
    #1;
    run_period(3, 5);
    run_period(3, 5);
    run_period(1, 1);
    idle_cyc(6);

    rst    = 1'b1;
    pwm_in = 1'b1;
    armed  = 1'b0;
    repeat (3) @(posedge ck);
    #1 rst = 1'b0;
    run_period(4, 4);
    run_period(4, 4);
    run_period(4, 4);
    run_period(1, 1);
    idle_cyc(10);

    chk("queue_empty", qp.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
